// File: rtl/dmem_arbiter_if.sv
// Bundle of core, loader and RAM port-B signals shared around dmem_arbiter.
// The arbiter connects through the slave modport; the surrounding system connects through master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  // Handshake: *_req is valid and *_gnt is ready. An access transfers in the cycle where req && gnt.
  // The requester holds req and its payload stable until that cycle. *_rvalid pulses one cycle
  // after a granted read (wstrb == 0), and *_rdata is zero whenever *_rvalid is low.
  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic [3:0]        c_wstrb;
  logic [31:0]       c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [31:0]       c_rdata;

  logic              l_req;
  logic [ADDR_W-1:0] l_addr;
  logic [3:0]        l_wstrb;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport master (
    output c_req, c_addr, c_wstrb, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output l_req, l_addr, l_wstrb, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_addr, m_wstrb, m_wdata,
    output m_rdata
  );

  modport slave (
    input  c_req, c_addr, c_wstrb, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  l_req, l_addr, l_wstrb, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output m_addr, m_wstrb, m_wdata,
    input  m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares RAM port B between the core LSU and the bulk loader, one access per cycle.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is core priority with a loader starvation counter.
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       resetb,
  dmem_arbiter_if.slave bus,
  output logic [3:0] dbg_wait_cnt,
  output logic       dbg_last_owner
);

  typedef enum logic {
    OWNER_CORE   = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_t;

  owner_t            last_owner;
  logic              rsp_c;
  logic              rsp_l;
  logic              c_win;
  logic              l_win;
  logic [ADDR_W-1:0] sel_addr;

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;
`endif

  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (bus.c_req && bus.l_req) begin
      l_win = (last_owner == OWNER_CORE);
    end else begin
      l_win = bus.l_req;
    end
`else
    l_win = bus.l_req && (!bus.c_req || (wait_cnt == WAIT_LIMIT));
`endif
    c_win = bus.c_req && !l_win;
    // Grants are suppressed while reset is held so the RAM never sees a write during reset.
    if (!resetb) begin
      c_win = 1'b0;
      l_win = 1'b0;
    end
  end

  assign sel_addr    = l_win ? bus.l_addr : bus.c_addr;
  assign bus.m_addr  = sel_addr;
  assign bus.m_wdata = l_win ? bus.l_wdata : bus.c_wdata;
  assign bus.m_wstrb = l_win ? bus.l_wstrb : (c_win ? bus.c_wstrb : 4'b0000);

  assign bus.c_gnt    = c_win;
  assign bus.l_gnt    = l_win;
  assign bus.c_rvalid = rsp_c;
  assign bus.l_rvalid = rsp_l;
  assign bus.c_rdata  = rsp_c ? bus.m_rdata : 32'h0;
  assign bus.l_rdata  = rsp_l ? bus.m_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rsp_c      <= 1'b0;
      rsp_l      <= 1'b0;
      last_owner <= OWNER_LOADER;
    end else begin
      rsp_c <= c_win && (bus.c_wstrb == 4'b0000);
      rsp_l <= l_win && (bus.l_wstrb == 4'b0000);
      if (c_win) begin
        last_owner <= OWNER_CORE;
      end else if (l_win) begin
        last_owner <= OWNER_LOADER;
      end
    end
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Counts consecutive denied loader cycles; at the limit the loader overrides the core.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wait_cnt <= 4'd0;
    end else if (!bus.l_req || l_win) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign dbg_wait_cnt = wait_cnt;
`else
  assign dbg_wait_cnt = 4'd0;
`endif

  assign dbg_last_owner = last_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default core-priority build) with a byte-strobed RAM model on port B.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;

  logic       clk;
  logic       resetb;
  logic [3:0] dbg_wait_cnt;
  logic       dbg_last_owner;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (4)
  ) dut (
    .clk            (clk),
    .resetb         (resetb),
    .bus            (bus),
    .dbg_wait_cnt   (dbg_wait_cnt),
    .dbg_last_owner (dbg_last_owner)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM model: writes commit at the edge, read data registered one cycle after address.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.m_wstrb[i]) mem[bus.m_addr][8*i +: 8] <= bus.m_wdata[8*i +: 8];
    end
    bus.m_rdata <= mem[bus.m_addr];
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
    bus.c_req   = req;
    bus.c_addr  = addr;
    bus.c_wstrb = wstrb;
    bus.c_wdata = wdata;
  endtask

  task automatic drive_l(input logic req, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
    bus.l_req   = req;
    bus.l_addr  = addr;
    bus.l_wstrb = wstrb;
    bus.l_wdata = wdata;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_core_rsp(input string tag);
    logic [31:0] exp;
    chk({tag, "_rvalid"}, 32'(bus.c_rvalid), 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, bus.c_rdata);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_rdata"}, bus.c_rdata, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetb   = 1'b0;
    drive_c(1'b1, 14'h005, 4'hF, 32'h5555_5555);
    drive_l(1'b1, 14'h006, 4'hF, 32'h6666_6666);
    #12;

    // Reset state, with both sides requesting
    chk("rst_c_gnt",      32'(bus.c_gnt),      32'd0);
    chk("rst_l_gnt",      32'(bus.l_gnt),      32'd0);
    chk("rst_m_wstrb",    32'(bus.m_wstrb),    32'd0);
    chk("rst_c_rvalid",   32'(bus.c_rvalid),   32'd0);
    chk("rst_l_rvalid",   32'(bus.l_rvalid),   32'd0);
    chk("rst_c_rdata",    bus.c_rdata,         32'd0);
    chk("rst_l_rdata",    bus.l_rdata,         32'd0);
    chk("rst_wait_cnt",   32'(dbg_wait_cnt),   32'd0);
    chk("rst_last_owner", 32'(dbg_last_owner), 32'd1);

    drive_c(1'b0, 14'h000, 4'h0, 32'h0);
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    cyc();

    // Loader preloads two words
    drive_l(1'b1, 14'h010, 4'hF, 32'hCAFE_0010);
    #1;
    chk("pre1_l_gnt",   32'(bus.l_gnt),   32'd1);
    chk("pre1_c_gnt",   32'(bus.c_gnt),   32'd0);
    chk("pre1_m_addr",  32'(bus.m_addr),  32'h010);
    chk("pre1_m_wstrb", 32'(bus.m_wstrb), 32'hF);
    cyc();
    chk("pre1_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    drive_l(1'b1, 14'h030, 4'hF, 32'h1122_3344);
    cyc();
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);

    // Core read of 0x010, loader idle
    drive_c(1'b1, 14'h010, 4'h0, 32'h0);
    #1;
    chk("rd10_c_gnt",   32'(bus.c_gnt),   32'd1);
    chk("rd10_m_wstrb", 32'(bus.m_wstrb), 32'd0);
    exp_q.push_back(32'hCAFE_0010);
    cyc();
    drive_c(1'b0, 14'h000, 4'h0, 32'h0);
    chk_core_rsp("rd10");
    chk("rd10_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    chk("rd10_l_rdata",  bus.l_rdata,       32'd0);

    // Loader write then core read of the same word next cycle
    drive_l(1'b1, 14'h020, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("wr20_l_gnt", 32'(bus.l_gnt), 32'd1);
    cyc();
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);
    drive_c(1'b1, 14'h020, 4'h0, 32'h0);
    chk("wr20_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("wr20_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    #1;
    chk("rd20_c_gnt", 32'(bus.c_gnt), 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    cyc();
    chk_core_rsp("rd20");
    chk("rd20_l_rvalid", 32'(bus.l_rvalid), 32'd0);

    // Single-byte strobe merge
    drive_c(1'b1, 14'h030, 4'b0100, 32'h00AB_0000);
    #1;
    chk("bs_m_wstrb", 32'(bus.m_wstrb), 32'h4);
    cyc();
    chk("bs_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    drive_c(1'b1, 14'h030, 4'h0, 32'h0);
    exp_q.push_back(32'h11AB_3344);
    cyc();
    chk_core_rsp("bs_rd");

    // Idle: no write, address follows the core
    drive_c(1'b0, 14'h123, 4'hF, 32'h0BAD_0BAD);
    drive_l(1'b0, 14'h3FF, 4'hF, 32'h7777_7777);
    #1;
    chk("idle_c_gnt",   32'(bus.c_gnt),   32'd0);
    chk("idle_l_gnt",   32'(bus.l_gnt),   32'd0);
    chk("idle_m_wstrb", 32'(bus.m_wstrb), 32'd0);
    chk("idle_m_addr",  32'(bus.m_addr),  32'h123);
    cyc();

    // Core requests every cycle, loader holds a read: loader wins in its 5th cycle
    drive_c(1'b1, 14'h010, 4'h0, 32'h0);
    drive_l(1'b1, 14'h020, 4'h0, 32'h0);
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk("starve_l_gnt",    32'(bus.l_gnt),             32'(k == 5));
      chk("starve_c_gnt",    32'(bus.c_gnt),             32'(k != 5));
      chk("starve_one_gnt",  32'(bus.c_gnt ^ bus.l_gnt), 32'd1);
      chk("starve_wait_cnt", 32'(dbg_wait_cnt),          32'(k - 1));
      if (k >= 2) begin
        chk("starve_c_rvalid", 32'(bus.c_rvalid), 32'd1);
        chk("starve_c_rdata",  bus.c_rdata,       32'hCAFE_0010);
      end
      cyc();
      #1;
    end
    chk("starve_l_rvalid",  32'(bus.l_rvalid), 32'd1);
    chk("starve_l_rdata",   bus.l_rdata,       32'hDEAD_BEEF);
    chk("starve_c_rvalid5", 32'(bus.c_rvalid), 32'd0);
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);
    #1;
    chk("post_c_gnt",    32'(bus.c_gnt),    32'd1);
    chk("post_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    cyc();

    // Alternating sides back-to-back
    drive_c(1'b0, 14'h000, 4'h0, 32'h0);
    drive_l(1'b1, 14'h030, 4'h0, 32'h0);
    chk("alt_c_rvalid0", 32'(bus.c_rvalid), 32'd1);
    #1;
    chk("alt_l_gnt", 32'(bus.l_gnt), 32'd1);
    cyc();
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);
    chk("alt_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("alt_l_rdata",  bus.l_rdata,       32'h11AB_3344);
    chk("alt_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("alt_c_rdata",  bus.c_rdata,       32'd0);

    // Reset while a core read is in flight
    drive_c(1'b1, 14'h010, 4'h0, 32'h0);
    #1;
    chk("inflt_c_gnt", 32'(bus.c_gnt), 32'd1);
    @(posedge clk);
    resetb = 1'b0;
    drive_l(1'b1, 14'h020, 4'h0, 32'h0);
    #1;
    chk("inflt_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("inflt_c_gnt_r",  32'(bus.c_gnt),    32'd0);
    chk("inflt_l_gnt_r",  32'(bus.l_gnt),    32'd0);
    cyc();
    cyc();
    chk("inflt_c_rvalid2", 32'(bus.c_rvalid), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    #1;
    chk("rel_c_rvalid",   32'(bus.c_rvalid),   32'd0);
    chk("rel_wait_cnt",   32'(dbg_wait_cnt),   32'd0);
    chk("rel_last_owner", 32'(dbg_last_owner), 32'd1);
    chk("rel_c_gnt",      32'(bus.c_gnt),      32'd1);
    chk("rel_l_gnt",      32'(bus.l_gnt),      32'd0);
    exp_q.push_back(32'hCAFE_0010);
    cyc();
    chk_core_rsp("rel_rd");
    chk("rel_wait_cnt1", 32'(dbg_wait_cnt), 32'd1);

    drive_c(1'b0, 14'h000, 4'h0, 32'h0);
    drive_l(1'b0, 14'h000, 4'h0, 32'h0);
    cyc();

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
